// File: rtl/rom_io_if.sv
// Pad-to-ROM read interface: synchronises cs_pad, sequences a wait-stated ROM access, registers data.
// Optional even parity output on par_pad when ROM_IO_PARITY_EN is defined.
module rom_io_if #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] adr_pad,
  input  logic              cs_pad,
  output logic [ADDR_W-1:0] adr_rom,
  output logic              cs_rom,
  input  logic [DATA_W-1:0] d_o_rom,
  output logic [DATA_W-1:0] d_o_pad,
  output logic              d_oe_pad,
  output logic              rdy_pad,
  output logic              busy
`ifdef ROM_IO_PARITY_EN
  ,
  output logic              par_pad
`endif
);

  localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

  state_t              r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                w_cs_s;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_adr, w_adr_nxt;
  logic [DATA_W-1:0]   r_dat, w_dat_nxt;
  logic                r_cs_rom, w_cs_rom_nxt;
  logic                r_rdy, w_rdy_nxt;
  logic                r_oe, w_oe_nxt;
  logic                w_load;

  // cs_pad is asynchronous; only the last synchroniser stage may reach the FSM
  assign w_cs_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_cs_rom <= 1'b0;
      r_rdy    <= 1'b0;
      r_oe     <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], cs_pad};
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_adr    <= w_adr_nxt;
      r_dat    <= w_dat_nxt;
      r_cs_rom <= w_cs_rom_nxt;
      r_rdy    <= w_rdy_nxt;
      r_oe     <= w_oe_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_adr_nxt    = r_adr;
    w_dat_nxt    = r_dat;
    w_cs_rom_nxt = r_cs_rom;
    w_rdy_nxt    = r_rdy;
    w_oe_nxt     = r_oe;
    w_load       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_cs_s) begin
          w_state_nxt  = StAccess;
          w_adr_nxt    = adr_pad;
          w_cs_rom_nxt = 1'b1;
          w_cnt_nxt    = '0;
        end
      end
      StAccess: begin
        // cs_s is deliberately ignored here so an access always runs to completion
        if (r_cnt == CNT_LAST) begin
          w_state_nxt  = StDone;
          w_load       = 1'b1;
          w_dat_nxt    = d_o_rom;
          w_cs_rom_nxt = 1'b0;
          w_rdy_nxt    = 1'b1;
          w_oe_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StDone: begin
        if (!w_cs_s) begin
          w_state_nxt = StIdle;
          w_rdy_nxt   = 1'b0;
          w_oe_nxt    = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = StIdle;
        w_cs_rom_nxt = 1'b0;
        w_rdy_nxt    = 1'b0;
        w_oe_nxt     = 1'b0;
      end
    endcase
  end

`ifdef ROM_IO_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= ^d_o_rom;
    end
  end

  assign par_pad = r_par;
`endif

  assign adr_rom  = r_adr;
  assign cs_rom   = r_cs_rom;
  assign d_o_pad  = r_dat;
  assign d_oe_pad = r_oe;
  assign rdy_pad  = r_rdy;
  assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_rom_io_if.sv
// Scoreboard bench for rom_io_if: default instance plus a WAIT_CYCLES=1, SYNC_STAGES=3 instance.
module tb_rom_io_if;

  typedef struct packed {
    logic [9:0]  adr;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  adr_pad;
  logic        cs_pad;
  logic [9:0]  adr_rom;
  logic        cs_rom;
  logic [31:0] d_o_rom;
  logic [31:0] d_o_pad;
  logic        d_oe_pad;
  logic        rdy_pad;
  logic        busy;

  logic [9:0]  adr2;
  logic        cs2;
  logic [9:0]  adr_rom2;
  logic        cs_rom2;
  logic [31:0] d_o_rom2;
  logic [31:0] d_o_pad2;
  logic        d_oe_pad2;
  logic        rdy2;
  logic        busy2;
`ifdef ROM_IO_PARITY_EN
  logic        par_pad;
  logic        par_pad2;
`endif

  int   n_total = 0;
  int   n_bad   = 0;
  int   n_rdy   = 0;
  int   n_burst = 0;
  exp_t exp_q[$];
  exp_t e_mon;
  logic prev_rdy = 1'b0;
  logic prev_cs  = 1'b0;
  int   cs_len   = 0;

  always #5 clk = ~clk;

  // ROM model: data = address * 3
  assign d_o_rom  = {22'd0, adr_rom} * 32'd3;
  assign d_o_rom2 = {22'd0, adr_rom2} * 32'd3;

  rom_io_if u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .adr_pad  (adr_pad),
    .cs_pad   (cs_pad),
    .adr_rom  (adr_rom),
    .cs_rom   (cs_rom),
    .d_o_rom  (d_o_rom),
    .d_o_pad  (d_o_pad),
    .d_oe_pad (d_oe_pad),
    .rdy_pad  (rdy_pad),
    .busy     (busy)
`ifdef ROM_IO_PARITY_EN
    ,
    .par_pad  (par_pad)
`endif
  );

  rom_io_if #(
    .SYNC_STAGES (3),
    .WAIT_CYCLES (1)
  ) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .adr_pad  (adr2),
    .cs_pad   (cs2),
    .adr_rom  (adr_rom2),
    .cs_rom   (cs_rom2),
    .d_o_rom  (d_o_rom2),
    .d_o_pad  (d_o_pad2),
    .d_oe_pad (d_oe_pad2),
    .rdy_pad  (rdy2),
    .busy     (busy2)
`ifdef ROM_IO_PARITY_EN
    ,
    .par_pad  (par_pad2)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [9:0] a);
    exp_q.push_back('{adr: a, dat: {22'd0, a} * 32'd3});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_adr_rom"}, 32'(adr_rom), 32'd0);
    check_eq({tag, "_cs_rom"}, 32'(cs_rom), 32'd0);
    check_eq({tag, "_d_o_pad"}, d_o_pad, 32'd0);
    check_eq({tag, "_d_oe_pad"}, 32'(d_oe_pad), 32'd0);
    check_eq({tag, "_rdy_pad"}, 32'(rdy_pad), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Full handshake: raise cs_pad, wait for rdy_pad, drop cs_pad for exactly one cycle
  task automatic read_hs(input logic [9:0] a);
    int budget;
    adr_pad = a;
    cs_pad  = 1'b1;
    push_exp(a);
    tick();
    tick();
    budget = 0;
    while (rdy_pad !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    check_eq("rdy_wait", 32'(rdy_pad), 32'd1);
    cs_pad = 1'b0;
    tick();
  endtask

  // Monitor on the default instance: address at access start, burst length, data at rdy rise
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rdy = 1'b0;
      prev_cs  = 1'b0;
      cs_len   = 0;
    end else begin
      if (cs_rom && !prev_cs) begin
        n_burst++;
        if (exp_q.size() == 0) check_eq("unexpected_access", 32'd1, 32'd0);
        else check_eq("adr_rom", 32'(adr_rom), 32'(exp_q[0].adr));
      end
      if (cs_rom) begin
        cs_len++;
      end else if (prev_cs) begin
        check_eq("cs_rom_len", cs_len, 32'd2);
        cs_len = 0;
      end
      if (rdy_pad && !prev_rdy) begin
        n_rdy++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_rdy", 32'd1, 32'd0);
        end else begin
          e_mon = exp_q.pop_front();
          check_eq("d_o_pad", d_o_pad, e_mon.dat);
          check_eq("d_oe_pad", 32'(d_oe_pad), 32'd1);
`ifdef ROM_IO_PARITY_EN
          check_eq("par_pad", 32'(par_pad), 32'(^e_mon.dat));
`endif
        end
      end
      prev_rdy = rdy_pad;
      prev_cs  = cs_rom;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n   = 1'b0;
    cs_pad  = 1'b0;
    adr_pad = '0;
    cs2     = 1'b0;
    adr2    = '0;
    #1;
    check_all_zero("rst");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_all_zero("post_rst");

    // Single read, then hold cs_pad for 20 cycles in total
    adr_pad = 10'h155;
    cs_pad  = 1'b1;
    push_exp(10'h155);
    tick();
    tick();
    check_eq("cs_rom_e1", 32'(cs_rom), 32'd0);
    tick();
    check_eq("cs_rom_e2", 32'(cs_rom), 32'd1);
    check_eq("adr_rom_e2", 32'(adr_rom), 32'h155);
    check_eq("busy_e2", 32'(busy), 32'd1);
    tick();
    check_eq("rdy_e3", 32'(rdy_pad), 32'd0);
    tick();
    check_eq("rdy_e4", 32'(rdy_pad), 32'd1);
    check_eq("d_oe_e4", 32'(d_oe_pad), 32'd1);
    check_eq("d_o_pad_e4", d_o_pad, 32'h3FF);
    check_eq("cs_rom_e4", 32'(cs_rom), 32'd0);
    cnt = 0;
    repeat (15) begin
      tick();
      if (rdy_pad === 1'b1) cnt++;
    end
    check_eq("rdy_hold", cnt, 32'd15);
    check_eq("single_burst", n_burst, 32'd1);
    cs_pad = 1'b0;
    tick();
    tick();
    check_eq("rdy_before_release", 32'(rdy_pad), 32'd1);
    tick();
    check_eq("rdy_release", 32'(rdy_pad), 32'd0);
    check_eq("d_oe_release", 32'(d_oe_pad), 32'd0);
    check_eq("busy_release", 32'(busy), 32'd0);
    check_eq("d_o_pad_kept", d_o_pad, 32'h3FF);
    tick();

    // Early drop: cs_pad high 3 cycles only
    adr_pad = 10'h2AA;
    push_exp(10'h2AA);
    cs_pad = 1'b1;
    repeat (3) tick();
    cs_pad = 1'b0;
    cnt = 0;
    repeat (10) begin
      tick();
      if (rdy_pad === 1'b1) cnt++;
    end
    check_eq("rdy_pulse", cnt, 32'd1);
    check_eq("d_o_pad_early", d_o_pad, 32'h7FE);

    // Back-to-back reads with one-cycle gaps
    read_hs(10'd0);
    read_hs(10'd1);
    read_hs(10'd2);
    read_hs(10'd1023);
    repeat (6) tick();
    check_eq("rdy_count", n_rdy, 32'd6);
    check_eq("burst_count", n_burst, 32'd6);
    check_eq("d_o_pad_last", d_o_pad, 32'd3069);
    check_eq("queue_empty", exp_q.size(), 32'd0);

    // Async reset in the middle of an access
    adr_pad = 10'h0F0;
    push_exp(10'h0F0);
    cs_pad = 1'b1;
    repeat (4) tick();
    check_eq("cs_rom_pre_rst", 32'(cs_rom), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    cs_pad = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check_eq("no_rdy_after_rst", n_rdy, 32'd6);
    check_all_zero("after_rst");

    // Second instance: SYNC_STAGES=3, WAIT_CYCLES=1
    adr2 = 10'h00A;
    cs2  = 1'b1;
    repeat (3) tick();
    check_eq("p_cs_rom_e2", 32'(cs_rom2), 32'd0);
    tick();
    check_eq("p_cs_rom_e3", 32'(cs_rom2), 32'd1);
    check_eq("p_adr_rom_e3", 32'(adr_rom2), 32'h00A);
    tick();
    check_eq("p_cs_rom_e4", 32'(cs_rom2), 32'd0);
    check_eq("p_rdy_e4", 32'(rdy2), 32'd1);
    check_eq("p_d_o_pad_e4", d_o_pad2, 32'd30);
`ifdef ROM_IO_PARITY_EN
    check_eq("p_par_pad", 32'(par_pad2), 32'd0);
`endif
    cs2 = 1'b0;
    repeat (6) tick();
    check_eq("p_rdy_release", 32'(rdy2), 32'd0);
    check_eq("p_busy_release", 32'(busy2), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
